// File: rtl/muldiv_seq.sv
// Purpose : RV32M multiply/divide sequencer beside the EX ALU; drives a shared pipelined
//           33x33 signed multiplier and runs an internal radix-2 restoring divider.
// Latency : mul ops MUL_LAT+1 cycles accept->result; div/rem 34 cycles; div special cases 1 cycle.
// Backpr. : one op in flight; req_ready_o only in IDLE; result held in DONE until res_ready_i.
// Ports   : clk/rst_n (async active-low); req_valid_i/req_ready_o + op_i/a_i/b_i request;
//           flush_i kills any op; mul_a_o/mul_b_o -> multiplier, mul_res_i <- product[63:0];
//           res_valid_o/res_ready_i + res_o result; busy_o high whenever not IDLE.
module muldiv_seq #(
  parameter int DATA_WIDTH = 32,
  parameter int MUL_LAT    = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [2:0]                op_i,
  input  logic [DATA_WIDTH-1:0]     a_i,
  input  logic [DATA_WIDTH-1:0]     b_i,
  input  logic                      flush_i,
  output logic [DATA_WIDTH:0]       mul_a_o,
  output logic [DATA_WIDTH:0]       mul_b_o,
  input  logic [2*DATA_WIDTH-1:0]   mul_res_i,
  output logic                      res_valid_o,
  input  logic                      res_ready_i,
  output logic [DATA_WIDTH-1:0]     res_o,
  output logic                      busy_o
);

  localparam int W     = DATA_WIDTH;
  // Counter must hold both the divider iteration index and the multiplier wait count.
  localparam int CNT_W = $clog2((MUL_LAT > W) ? MUL_LAT : W);

  localparam logic [W-1:0] ALL_ONES = {W{1'b1}};
  localparam logic [W-1:0] INT_MIN  = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    MUL_WAIT = 3'd1,
    DIV_CALC = 3'd2,
    DIV_FIX  = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;          // op[2] is implied by the state path taken
  logic [W:0]       mul_a_q, mul_a_d;
  logic [W:0]       mul_b_q, mul_b_d;
  logic [W-1:0]     rem_q, rem_d;
  logic [W-1:0]     quo_q, quo_d;        // dividend shifts out MSB-first as quotient shifts in
  logic [W-1:0]     dvs_q, dvs_d;
  logic             neg_q_q, neg_q_d;    // negate quotient in DIV_FIX
  logic             neg_r_q, neg_r_d;    // negate remainder in DIV_FIX
  logic [W-1:0]     res_q, res_d;

  logic             accept;
  logic             div_signed;
  logic [W-1:0]     a_mag, b_mag;
  logic [W:0]       rem_sh, diff;
  logic             ge;

  assign req_ready_o = (state_q == IDLE);
  assign busy_o      = (state_q != IDLE);
  assign res_valid_o = (state_q == DONE);
  assign res_o       = res_q;
  assign mul_a_o     = mul_a_q;
  assign mul_b_o     = mul_b_q;

  // A request coinciding with a flush is dropped, not accepted.
  assign accept = req_valid_i & (state_q == IDLE) & ~flush_i;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    mul_a_d    = mul_a_q;
    mul_b_d    = mul_b_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dvs_d      = dvs_q;
    neg_q_d    = neg_q_q;
    neg_r_d    = neg_r_q;
    res_d      = res_q;

    // div/rem (op[0]=0) are signed; divu/remu unsigned.
    div_signed = ~op_i[0];
    a_mag      = (div_signed & a_i[W-1]) ? -a_i : a_i;
    b_mag      = (div_signed & b_i[W-1]) ? -b_i : b_i;

    // Restoring step: the borrow bit of the trial subtraction is the inverted quotient bit.
    rem_sh     = {rem_q, quo_q[W-1]};
    diff       = rem_sh - {1'b0, dvs_q};
    ge         = ~diff[W];

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          op_d = op_i[1:0];
          if (!op_i[2]) begin
            // rs1 signed for mul/mulh/mulhsu, rs2 signed for mul/mulh only.
            mul_a_d = {a_i[W-1] & (op_i[1:0] != 2'b11), a_i};
            mul_b_d = {b_i[W-1] & ~op_i[1], b_i};
            cnt_d   = CNT_W'(MUL_LAT - 1);
            state_d = MUL_WAIT;
          end else if (b_i == '0) begin
            res_d   = op_i[1] ? a_i : ALL_ONES;
            state_d = DONE;
          end else if (div_signed && (a_i == INT_MIN) && (b_i == ALL_ONES)) begin
            res_d   = op_i[1] ? '0 : INT_MIN;
            state_d = DONE;
          end else begin
            quo_d   = a_mag;
            dvs_d   = b_mag;
            rem_d   = '0;
            neg_q_d = div_signed & (a_i[W-1] ^ b_i[W-1]);
            neg_r_d = div_signed & a_i[W-1];
            cnt_d   = CNT_W'(W - 1);
            state_d = DIV_CALC;
          end
        end
      end

      MUL_WAIT: begin
        if (cnt_q == '0) begin
          res_d   = (op_q == 2'b00) ? mul_res_i[W-1:0] : mul_res_i[2*W-1:W];
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      DIV_CALC: begin
        rem_d = ge ? diff[W-1:0] : rem_sh[W-1:0];
        quo_d = {quo_q[W-2:0], ge};
        if (cnt_q == '0) begin
          state_d = DIV_FIX;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      DIV_FIX: begin
        if (op_q[1]) begin
          res_d = neg_r_q ? -rem_q : rem_q;
        end else begin
          res_d = neg_q_q ? -quo_q : quo_q;
        end
        state_d = DONE;
      end

      DONE: begin
        if (res_ready_i) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    // Pipeline kill wins over every transition, including the result handshake.
    if (flush_i) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      mul_a_q <= '0;
      mul_b_q <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
      res_q   <= res_d;
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Purpose : directed + short random checks of muldiv_seq with a behavioural multiplier.
// Latency : multiplier model has MUL_LAT-1 register stages after the operand registers.
// Backpr. : bench drives res_ready_i, optionally holding it low to stall DONE.
module tb_muldiv_seq;

  localparam int MUL_LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [2:0]  op_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        flush_i;
  logic [32:0] mul_a_o;
  logic [32:0] mul_b_o;
  logic [63:0] mul_res_i;
  logic        res_valid_o;
  logic        res_ready_i;
  logic [31:0] res_o;
  logic        busy_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb[$];

  muldiv_seq #(.DATA_WIDTH(32), .MUL_LAT(MUL_LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o),
    .op_i       (op_i),
    .a_i        (a_i),
    .b_i        (b_i),
    .flush_i    (flush_i),
    .mul_a_o    (mul_a_o),
    .mul_b_o    (mul_b_o),
    .mul_res_i  (mul_res_i),
    .res_valid_o(res_valid_o),
    .res_ready_i(res_ready_i),
    .res_o      (res_o),
    .busy_o     (busy_o)
  );

  always #5 clk = ~clk;

  // Shared multiplier: operands valid from cycle 1, product valid in cycle MUL_LAT (=2).
  logic signed [65:0] prod_full;
  assign prod_full = $signed(mul_a_o) * $signed(mul_b_o);
  always_ff @(posedge clk) mul_res_i <= prod_full[63:0];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference result straight from the RV32M definitions.
  function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb_;
    logic [63:0] ua, ub, p;
    sa  = $signed(a);
    sb_ = $signed(b);
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    case (op)
      3'd0: begin p = sa * sb_;  return p[31:0];  end
      3'd1: begin p = sa * sb_;  return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin p = ua * ub;   return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb_; return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb_; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (!op[2]) return MUL_LAT + 1;
    if (b == 0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  // One full request/result transaction; exp is pushed at drive time, popped at handshake.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int hold);
    int          cyc;
    logic [31:0] held;
    logic [32:0] ea, eb;
    ea = {a[31] & (op == 3'd0 || op == 3'd1 || op == 3'd2), a};
    eb = {b[31] & (op == 3'd0 || op == 3'd1), b};
    @(negedge clk);
    chk({tag, "_req_ready"}, 64'(req_ready_o), 64'd1);
    req_valid_i = 1'b1; op_i = op; a_i = a; b_i = b;
    sb.push_back(exp);
    @(posedge clk); #1;
    req_valid_i = 1'b0; a_i = '0; b_i = '0;
    cyc = 0;
    while (cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1 && !op[2]) begin
        chk({tag, "_mul_a"}, 64'(mul_a_o), 64'(ea));
        chk({tag, "_mul_b"}, 64'(mul_b_o), 64'(eb));
      end
      if (res_valid_o) break;
    end
    chk({tag, "_latency"}, 64'(cyc), 64'(ref_lat(op, a, b)));
    held = res_o;
    repeat (hold) begin
      @(negedge clk);
      chk({tag, "_hold_valid"}, 64'(res_valid_o), 64'd1);
      chk({tag, "_hold_res"}, 64'(res_o), 64'(held));
      chk({tag, "_hold_ready"}, 64'(req_ready_o), 64'd0);
    end
    res_ready_i = 1'b1;
    chk({tag, "_res"}, 64'(res_o), 64'(sb.pop_front()));
    @(posedge clk); #1;
    res_ready_i = 1'b0;
  endtask

  initial begin
    int vhits;
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    rst_n = 1'b0; req_valid_i = 1'b0; op_i = '0; a_i = '0; b_i = '0;
    flush_i = 1'b0; res_ready_i = 1'b0;
    #12;
    chk("rst_req_ready", 64'(req_ready_o), 64'd1);
    chk("rst_res_valid", 64'(res_valid_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_res", 64'(res_o), 64'd0);
    chk("rst_mul_a", 64'(mul_a_o), 64'd0);
    chk("rst_mul_b", 64'(mul_b_o), 64'd0);
    @(negedge clk); rst_n = 1'b1;

    // Multiplies
    run_op("mul_7_m3",  3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 0);
    run_op("mulhsu_m1", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op("mulhu_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
    run_op("mulh_neg",  3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0);

    // Divides
    run_op("div_m20_3",  3'd4, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA, 0);
    run_op("rem_m20_3",  3'd6, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE, 0);
    run_op("divu_100_7", 3'd5, 32'd100,       32'd7, 32'd14,        0);
    run_op("remu_100_7", 3'd7, 32'd100,       32'd7, 32'd2,         0);

    // Special cases
    run_op("div_by0",  3'd4, 32'd5,         32'd0,         32'hFFFF_FFFF, 0);
    run_op("rem_by0",  3'd6, 32'd5,         32'd0,         32'd5,         0);
    run_op("divu_by0", 3'd5, 32'd9,         32'd0,         32'hFFFF_FFFF, 0);
    run_op("div_ovf",  3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
    run_op("rem_ovf",  3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         0);

    // Result stalled in DONE for 5 cycles, then back-to-back request
    run_op("stall_div", 3'd4, 32'd1000, 32'hFFFF_FFF9, 32'hFFFF_FF72, 5);
    run_op("b2b_mul",   3'd0, 32'd12,   32'd11,        32'd132,       0);

    // Short random mix against the reference model
    for (int i = 0; i < 8; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = (i == 3) ? 32'd0 : $urandom;
      run_op("rand", rop, ra, rb, ref_res(rop, ra, rb), i % 2);
    end

    // Flush during DIV_CALC at iteration 10
    @(negedge clk);
    req_valid_i = 1'b1; op_i = 3'd4; a_i = 32'd12345; b_i = 32'd17;
    @(posedge clk); #1; req_valid_i = 1'b0;
    repeat (11) @(negedge clk);
    chk("flush_busy_before", 64'(busy_o), 64'd1);
    flush_i = 1'b1;
    @(posedge clk); #1; flush_i = 1'b0;
    @(negedge clk);
    chk("flush_busy_after", 64'(busy_o), 64'd0);
    chk("flush_req_ready", 64'(req_ready_o), 64'd1);
    vhits = 0;
    repeat (40) begin @(negedge clk); if (res_valid_o) vhits++; end
    chk("flush_no_result", 64'(vhits), 64'd0);

    // Request presented together with flush is dropped
    @(negedge clk);
    req_valid_i = 1'b1; flush_i = 1'b1; op_i = 3'd0; a_i = 32'd3; b_i = 32'd3;
    @(posedge clk); #1; req_valid_i = 1'b0; flush_i = 1'b0;
    @(negedge clk);
    chk("flush_req_dropped", 64'(busy_o), 64'd0);

    // Reset asserted while in MUL_WAIT
    @(negedge clk);
    req_valid_i = 1'b1; op_i = 3'd0; a_i = 32'd7; b_i = 32'hFFFF_FFFD;
    @(posedge clk); #1; req_valid_i = 1'b0;
    chk("midrst_busy_before", 64'(busy_o), 64'd1);
    #2; rst_n = 1'b0; #1;
    chk("midrst_req_ready", 64'(req_ready_o), 64'd1);
    chk("midrst_res_valid", 64'(res_valid_o), 64'd0);
    chk("midrst_busy", 64'(busy_o), 64'd0);
    chk("midrst_res", 64'(res_o), 64'd0);
    chk("midrst_mul_a", 64'(mul_a_o), 64'd0);
    chk("midrst_mul_b", 64'(mul_b_o), 64'd0);
    @(negedge clk); rst_n = 1'b1;

    run_op("post_rst_remu", 3'd7, 32'd50, 32'd8, 32'd2, 0);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
